// File: rtl/dmem_lsu.sv
// Load/store unit between the memory stage and a word-wide dmem port.
// Takes one byte-addressed request per handshake and uses read-modify-write for sub-word stores.
module dmem_lsu #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_write_enable,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_writedata,
  input  logic [N-1:0] mem_readdata
);

  localparam int L = N / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t         state_reg, state_next;
  logic           we_reg, signed_reg, err_reg;
  logic [1:0]     size_reg;
  logic [N-1:0]   addr_reg, wdata_reg, rdata_reg;
  logic           accept, misaligned;
  logic [L-1:0]   lane_en;
  logic [N-1:0]   wdata_aligned, merged, shifted, load_data;

  assign req_ready = (state_reg == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_addr  = {2'b00, addr_reg[N-1:2]};

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      err_reg    <= 1'b0;
      size_reg   <= 2'b00;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        we_reg     <= req_we;
        signed_reg <= req_signed;
        err_reg    <= misaligned;
        size_reg   <= req_size;
        addr_reg   <= req_addr;
        wdata_reg  <= req_wdata;
      end
      if (state_reg == RD) rdata_reg <= mem_readdata;
    end
  end

  // Store data is replicated across all lanes; lane_en picks which lanes overwrite the read word.
  always_comb begin
    lane_en       = '1;
    wdata_aligned = wdata_reg;
    case (size_reg)
      2'b00: begin
        lane_en       = L'(1) << addr_reg[1:0];
        wdata_aligned = {L{wdata_reg[7:0]}};
      end
      2'b01: begin
        lane_en       = L'(3) << {addr_reg[1], 1'b0};
        wdata_aligned = {(L/2){wdata_reg[15:0]}};
      end
      default: begin
        lane_en       = '1;
        wdata_aligned = wdata_reg;
      end
    endcase
  end

  generate
    for (genvar gi = 0; gi < L; gi++) begin : g_lane
      assign merged[8*gi +: 8] = lane_en[gi] ? wdata_aligned[8*gi +: 8] : rdata_reg[8*gi +: 8];
    end
  endgenerate

  assign shifted = rdata_reg >> {addr_reg[1:0], 3'b000};

  always_comb begin
    load_data = shifted;
    case (size_reg)
      2'b00:   load_data = {{(N-8){signed_reg & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{(N-16){signed_reg & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    mem_write_enable = 1'b0;
    mem_writedata    = '0;
    resp_valid       = 1'b0;
    resp_err         = 1'b0;
    resp_rdata       = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (misaligned)                      state_next = RESP;
          else if (req_we && req_size == 2'b10) state_next = WR;
          else                                 state_next = RD;
        end
      end
      RD: state_next = we_reg ? WR : RESP;
      WR: begin
        mem_write_enable = 1'b1;
        mem_writedata    = merged;
        state_next       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        if (!err_reg && !we_reg) resp_rdata = load_data;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a small behavioural word memory on the dmem port.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] mem [0:15];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign mem_readdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write_enable) mem[mem_addr[3:0]] <= mem_writedata;

  dmem_lsu #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_wr, input logic [31:0] exp_waddr,
                        input logic [31:0] exp_wdata);
    int lat;
    int wrs;
    logic [31:0] wa;
    logic [31:0] wd;
    lat = 1;
    wrs = 0;
    wa  = '0;
    wd  = '0;
    chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    tick();
    req_valid = 1'b0;
    while (!resp_valid && lat < 6) begin
      if (mem_write_enable) begin
        wrs++;
        wa = mem_addr;
        wd = mem_writedata;
      end
      chk({tag, "_busy"}, {31'b0, req_ready}, 32'd0);
      tick();
      lat++;
    end
    chk({tag, "_resp"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    chk({tag, "_wrs"}, wrs, exp_wr);
    if (exp_wr > 0) begin
      chk({tag, "_waddr"}, wa, exp_waddr);
      chk({tag, "_wdata"}, wd, exp_wdata);
    end
    tick();
    chk({tag, "_resp_end"}, {31'b0, resp_valid}, 32'd0);
    $display("req %s we=%0b size=%0d addr=%h rdata=%h err=%0b lat=%0d", tag, we, size, addr,
             resp_rdata, exp_err, lat);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h0000_FFFF;
    mem[5] = 32'h1111_2222;
    mem[6] = 32'h3333_4444;

    // reset state
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: word store
    do_req("sw0", 1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF, 2, 32'h0, 1'b0, 1, 32'd0, 32'hFFFF_FFFF);
    chk("mem0_after_sw", mem[0], 32'hFFFF_FFFF);
    // 2: byte store via RMW
    do_req("sb5", 1'b1, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 3, 32'h0, 1'b0, 1, 32'd1, 32'h0000_ABFF);
    chk("mem1_after_sb", mem[1], 32'h0000_ABFF);
    // 3: loads
    do_req("lb5", 1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 2, 32'hFFFF_FFAB, 1'b0, 0, 32'h0, 32'h0);
    do_req("lbu5", 1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 2, 32'h0000_00AB, 1'b0, 0, 32'h0, 32'h0);
    do_req("lh6", 1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 2, 32'h0000_0000, 1'b0, 0, 32'h0, 32'h0);
    do_req("lw4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2, 32'h0000_ABFF, 1'b0, 0, 32'h0, 32'h0);
    do_req("lh4", 1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 2, 32'hFFFF_ABFF, 1'b0, 0, 32'h0, 32'h0);
    do_req("lhu4", 1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 2, 32'h0000_ABFF, 1'b0, 0, 32'h0, 32'h0);
    // upper-lane half and byte stores
    do_req("sh2", 1'b1, 2'b01, 1'b0, 32'h2, 32'hDEAD_1234, 3, 32'h0, 1'b0, 1, 32'd0, 32'h1234_FFFF);
    do_req("sb3", 1'b1, 2'b00, 1'b0, 32'h3, 32'hFFFF_FF5A, 3, 32'h0, 1'b0, 1, 32'd0, 32'h5A34_FFFF);
    do_req("lb3", 1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 2, 32'h0000_005A, 1'b0, 0, 32'h0, 32'h0);
    // 4: errors
    do_req("sw2_err", 1'b1, 2'b10, 1'b0, 32'h2, 32'h1234_5678, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
    do_req("lh3_err", 1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
    do_req("sz11_err", 1'b1, 2'b11, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0);
    chk("mem0_after_err", mem[0], 32'h5A34_FFFF);

    // 5: reset in the middle of the WR cycle of a byte store
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h77;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid_in_wr", {31'b0, mem_write_enable}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_drop", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("rst_mid_no_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_mem2", mem[2], 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_mid_no_resp2", {31'b0, resp_valid}, 32'd0);
    do_req("lw4_post", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 2, 32'h0000_ABFF, 1'b0, 0, 32'h0, 32'h0);
    chk("mem2_post_rst", mem[2], 32'h0);

    // 6: req_valid held high across two word loads
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h14;
    tick();
    req_addr = 32'h18;
    chk("q_rd1_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("q_resp1_valid", {31'b0, resp_valid}, 32'd1);
    chk("q_resp1_ready", {31'b0, req_ready}, 32'd0);
    chk("q_resp1_rdata", resp_rdata, 32'h1111_2222);
    tick();
    chk("q_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("q_idle_resp", {31'b0, resp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("q_rd2_ready", {31'b0, req_ready}, 32'd0);
    tick();
    chk("q_resp2_valid", {31'b0, resp_valid}, 32'd1);
    chk("q_resp2_ready", {31'b0, req_ready}, 32'd0);
    chk("q_resp2_rdata", resp_rdata, 32'h3333_4444);
    $display("req queued loads resp1=%h resp2=%h", 32'h1111_2222, resp_rdata);
    tick();
    chk("q_end_ready", {31'b0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
